// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcode/funct
// values, datapath select codes and the decoded instruction-class vector.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JUMP = 2'd2;
    localparam logic [1:0] NPC_REG  = 2'd3;

    // Also consumed by the immediate extender in the datapath.
    localparam logic [1:0] EXT_SIGN     = 2'd0;
    localparam logic [1:0] EXT_ZERO     = 2'd1;
    localparam logic [1:0] EXT_UPPER    = 2'd2;
    localparam logic [1:0] EXT_SIGN_SH2 = 2'd3;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_OR    = 3'd2;
    localparam logic [2:0] ALU_PASSB = 3'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    typedef struct packed {
        logic rtype_addu;
        logic rtype_subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic nop;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct to one-hot instruction class; anything unsupported is a NOP.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls.rtype_addu = 1'b1;
                    FN_SUBU: cls.rtype_subu = 1'b1;
                    FN_JR:   cls.jr         = 1'b1;
                    default: cls.nop        = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register, per-state datapath control
// decode and the retired-instruction counter.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int RA_IDX = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_wr,
    output logic [1:0]  npc_sel,
    output logic        ir_wr,
    output logic [1:0]  eop,
    output logic [2:0]  alu_op,
    output logic        alu_bsel,
    output logic        reg_wr,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        mem_wr,
    output logic [2:0]  state,
    output logic        retire,
    output logic [31:0] instr_cnt
);

    // The datapath resolves reg_dst=DST_RA to this index; it must name a GPR.
    if (RA_IDX < 0 || RA_IDX > 31) begin : g_ra_range
        $error("RA_IDX must be a register index in 0..31");
    end

    iclass_t cls;
    state_t  st, st_nxt;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
    );

    assign state = st;

    always_comb begin
        pc_wr    = 1'b0;
        npc_sel  = NPC_PC4;
        ir_wr    = 1'b0;
        eop      = EXT_SIGN;
        alu_op   = ALU_ADD;
        alu_bsel = 1'b0;
        reg_wr   = 1'b0;
        reg_dst  = DST_RT;
        wd_sel   = WD_ALU;
        mem_wr   = 1'b0;
        retire   = 1'b0;
        st_nxt   = S_FETCH;
        case (st)
            S_FETCH: begin
                ir_wr  = 1'b1;
                pc_wr  = 1'b1;
                st_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (cls.j || cls.jal) begin
                    pc_wr   = 1'b1;
                    npc_sel = NPC_JUMP;
                end
                if (cls.jal) begin
                    reg_wr  = 1'b1;
                    reg_dst = DST_RA;
                    wd_sel  = WD_PC4;
                end
                if (cls.jr) begin
                    pc_wr   = 1'b1;
                    npc_sel = NPC_REG;
                end
                if (cls.j || cls.jal || cls.jr || cls.nop)
                    retire = 1'b1;
                else
                    st_nxt = S_EXE;
            end
            S_EXE: begin
                if (cls.rtype_subu)
                    alu_op = ALU_SUB;
                if (cls.ori) begin
                    eop      = EXT_ZERO;
                    alu_op   = ALU_OR;
                    alu_bsel = 1'b1;
                end
                if (cls.lui) begin
                    eop      = EXT_UPPER;
                    alu_op   = ALU_PASSB;
                    alu_bsel = 1'b1;
                end
                if (cls.lw || cls.sw)
                    alu_bsel = 1'b1;
                // Branch target is formed from the word-scaled offset while the ALU compares.
                if (cls.beq) begin
                    alu_op  = ALU_SUB;
                    eop     = EXT_SIGN_SH2;
                    npc_sel = NPC_BR;
                    pc_wr   = zero;
                    retire  = 1'b1;
                end else if (cls.lw || cls.sw) begin
                    st_nxt = S_MEM;
                end else begin
                    st_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (cls.sw) begin
                    mem_wr = 1'b1;
                    retire = 1'b1;
                end else begin
                    st_nxt = S_WB;
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                reg_dst = (cls.rtype_addu || cls.rtype_subu) ? DST_RD : DST_RT;
                wd_sel  = cls.lw ? WD_MEM : WD_ALU;
                retire  = 1'b1;
            end
            default: st_nxt = S_FETCH;
        endcase
        // Held reset must not leak FETCH's enables onto the datapath.
        if (reset) begin
            {pc_wr, npc_sel, ir_wr, eop, alu_op, alu_bsel} = '0;
            {reg_wr, reg_dst, wd_sel, mem_wr, retire}      = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= S_FETCH;
            instr_cnt <= '0;
        end else begin
            st <= st_nxt;
            if (retire)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instruction
// streams compared against a per-instruction micro-sequence model.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        pc_wr, ir_wr, alu_bsel, reg_wr, mem_wr, retire;
    logic [1:0]  npc_sel, eop, reg_dst, wd_sel;
    logic [2:0]  alu_op, state;
    logic [31:0] instr_cnt;

    mc_ctrl #(.RA_IDX(31)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .pc_wr     (pc_wr),
        .npc_sel   (npc_sel),
        .ir_wr     (ir_wr),
        .eop       (eop),
        .alu_op    (alu_op),
        .alu_bsel  (alu_bsel),
        .reg_wr    (reg_wr),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .mem_wr    (mem_wr),
        .state     (state),
        .retire    (retire),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] model_cnt = '0;

    typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                      K_J, K_JAL, K_JR, K_NOP} kind_t;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_wr;
        logic [1:0] npc_sel;
        logic       ir_wr;
        logic [1:0] eop;
        logic [2:0] alu_op;
        logic       alu_bsel;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       mem_wr;
        logic       retire;
    } ctl_t;

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                case (fn)
                    6'h21:   return K_ADDU;
                    6'h23:   return K_SUBU;
                    6'h08:   return K_JR;
                    default: return K_NOP;
                endcase
            end
            6'h0D:   return K_ORI;
            6'h0F:   return K_LUI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic int cycles_of(input kind_t k);
        case (k)
            K_J, K_JAL, K_JR, K_NOP: return 2;
            K_BEQ:                   return 3;
            K_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Expected control word for cycle 'step' of an instruction of kind k.
    function automatic ctl_t expect_step(input kind_t k, input int step, input logic z);
        ctl_t e = '0;
        logic wb = 1'b0;
        e.retire = (step == cycles_of(k) - 1);
        case (step)
            0: begin
                e.state = 3'd0; e.pc_wr = 1'b1; e.ir_wr = 1'b1;
            end
            1: begin
                e.state = 3'd1;
                case (k)
                    K_J:   begin e.pc_wr = 1'b1; e.npc_sel = 2'd2; end
                    K_JAL: begin
                        e.pc_wr = 1'b1; e.npc_sel = 2'd2;
                        e.reg_wr = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
                    end
                    K_JR:  begin e.pc_wr = 1'b1; e.npc_sel = 2'd3; end
                    default: ;
                endcase
            end
            2: begin
                e.state = 3'd2;
                case (k)
                    K_SUBU: e.alu_op = 3'd1;
                    K_ORI:  begin e.eop = 2'd1; e.alu_op = 3'd2; e.alu_bsel = 1'b1; end
                    K_LUI:  begin e.eop = 2'd2; e.alu_op = 3'd3; e.alu_bsel = 1'b1; end
                    K_LW, K_SW: e.alu_bsel = 1'b1;
                    K_BEQ:  begin
                        e.alu_op = 3'd1; e.eop = 2'd3; e.npc_sel = 2'd1; e.pc_wr = z;
                    end
                    default: ;
                endcase
            end
            3: begin
                if (k == K_LW || k == K_SW) begin
                    e.state = 3'd3;
                    e.mem_wr = (k == K_SW);
                end else begin
                    wb = 1'b1;
                end
            end
            4: wb = 1'b1;
            default: ;
        endcase
        if (wb) begin
            e.state   = 3'd4;
            e.reg_wr  = 1'b1;
            e.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
            e.wd_sel  = (k == K_LW) ? 2'd1 : 2'd0;
        end
        return e;
    endfunction

    function automatic ctl_t observed();
        ctl_t o;
        o.state = state; o.pc_wr = pc_wr; o.npc_sel = npc_sel; o.ir_wr = ir_wr;
        o.eop = eop; o.alu_op = alu_op; o.alu_bsel = alu_bsel; o.reg_wr = reg_wr;
        o.reg_dst = reg_dst; o.wd_sel = wd_sel; o.mem_wr = mem_wr; o.retire = retire;
        return o;
    endfunction

    // Runs one instruction starting in FETCH; zmode 0/1 fixes zero, 2 randomises it
    // per cycle. abort_at >= 0 asserts reset on that cycle instead of completing.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                             input int abort_at, input string tag);
        kind_t k = classify(op, fn);
        int    n = cycles_of(k);
        ctl_t  ex, got;
        for (int s = 0; s < n; s++) begin
            opcode = op;
            funct  = fn;
            zero   = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            if (s == abort_at) begin
                reset = 1'b1;
                #1;
                got = observed();
                n_checks++;
                if (got !== ctl_t'('0)) begin
                    n_fail++;
                    $display("FAIL %s abort ctl: got %h expected %h", tag, got, ctl_t'('0));
                end
                n_checks++;
                if (instr_cnt !== 32'd0) begin
                    n_fail++;
                    $display("FAIL %s abort cnt: got %h expected 0", tag, instr_cnt);
                end
                @(negedge clk);
                reset = 1'b0;
                model_cnt = '0;
                return;
            end
            #1;
            ex  = expect_step(k, s, zero);
            got = observed();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL %s op=%h fn=%h step %0d ctl: got %h expected %h",
                         tag, op, fn, s, got, ex);
            end
            n_checks++;
            if (instr_cnt !== model_cnt) begin
                n_fail++;
                $display("FAIL %s step %0d instr_cnt: got %h expected %h",
                         tag, s, instr_cnt, model_cnt);
            end
            @(negedge clk);
        end
        model_cnt = model_cnt + 32'd1;
    endtask

    task automatic check_cnt(input string tag);
        #1;
        n_checks++;
        if (instr_cnt !== model_cnt) begin
            n_fail++;
            $display("FAIL %s instr_cnt: got %h expected %h", tag, instr_cnt, model_cnt);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'h0D;
        @(negedge clk);
        #1;
        n_checks++;
        if (observed() !== ctl_t'('0)) begin
            n_fail++;
            $display("FAIL reset ctl: got %h expected %h", observed(), ctl_t'('0));
        end
        n_checks++;
        if (instr_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset instr_cnt: got %h expected 0", instr_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        model_cnt = '0;
    endtask

    task automatic test_ori();
        run_instr(6'h0D, $urandom_range(0, 63), 2, -1, "ori");
        check_cnt("ori_done");
    endtask

    task automatic test_beq();
        run_instr(6'h04, 6'h00, 1, -1, "beq_z1");
        run_instr(6'h04, 6'h00, 0, -1, "beq_z0");
    endtask

    task automatic test_lw_sw();
        run_instr(6'h23, 6'h00, 2, -1, "lw");
        run_instr(6'h2B, 6'h00, 2, -1, "sw");
        check_cnt("lw_sw_done");
    endtask

    task automatic test_jal_nop();
        run_instr(6'h03, 6'h00, 2, -1, "jal");
        run_instr(6'h3F, 6'h00, 2, -1, "nop");
        run_instr(6'h00, 6'h02, 2, -1, "rnop");
        run_instr(6'h00, 6'h08, 2, -1, "jr");
        run_instr(6'h02, 6'h00, 2, -1, "j");
    endtask

    task automatic test_reset_mid();
        run_instr(6'h0F, 6'h00, 2, 2, "lui_abort");
        run_instr(6'h0F, 6'h00, 2, -1, "lui_after");
        check_cnt("lui_after_done");
    endtask

    task automatic test_wrap();
        force dut.instr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.instr_cnt;
        model_cnt = 32'hFFFF_FFFF;
        run_instr(6'h3F, 6'h00, 2, -1, "wrap_nop");
        check_cnt("wrap_zero");
        run_instr(6'h00, 6'h21, 2, -1, "wrap_addu");
    endtask

    task automatic test_random();
        logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
        logic [5:0] fns [10] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};
        logic [5:0] op, fn;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                int idx = $urandom_range(0, 9);
                op = ops[idx];
                fn = fns[idx];
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr(op, fn, 2, -1, "random");
        end
        check_cnt("random_done");
    endtask

    initial begin
        test_reset();
        test_ori();
        test_beq();
        test_lw_sw();
        test_jal_nop();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle MIPS control unit that sequences the shared datapath: PC, IR, register file, immediate extender, ALU and data memory. It runs a five-state FSM, one instruction at a time. Each cycle it drives the write enables and mux selects, including the 2-bit extender mode `eop`. It sits beside the datapath in the multi-cycle CPU top and decodes the opcode/funct fields of the IR.

## Interface
Parameters
- `RA_IDX`, default 31: destination register for `jal`.

Ports
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]. Stable from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU equality flag, valid in EXE.
- `pc_wr`  out  1  PC write enable.
- `npc_sel`  out  2  next-PC source: 0 PC+4, 1 branch (PC+4+ext), 2 jump (26-bit index), 3 GPR[rs].
- `ir_wr`  out  1  IR write enable.
- `eop`  out  2  extender mode: 0 sign, 1 zero, 2 upper (imm<<16), 3 sign<<2.
- `alu_op`  out  3  0 add, 1 sub, 2 or, 3 pass-B.
- `alu_bsel`  out  1  0 GPR[rt], 1 extender output.
- `reg_wr`  out  1  GPR write enable.
- `reg_dst`  out  2  0 rt, 1 rd, 2 `RA_IDX`.
- `wd_sel`  out  2  0 ALU result, 1 memory data, 2 PC+4.
- `mem_wr`  out  1  data memory write enable.
- `state`  out  3  current FSM state, for debug.
- `retire`  out  1  one-cycle pulse on the last cycle of each instruction.
- `instr_cnt`  out  32  retired-instruction counter.

## Operation
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr. Any other opcode/funct is a NOP.
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Values 5–7 are illegal and return to FETCH on the next edge with no enables asserted.
- FETCH: `ir_wr`=1, `pc_wr`=1, `npc_sel`=0. Next state DECODE.
- DECODE:
  - j: `pc_wr`=1, `npc_sel`=2.
  - jal: same as j, plus `reg_wr`=1, `reg_dst`=2, `wd_sel`=2.
  - jr: `pc_wr`=1, `npc_sel`=3.
  - All three then go to FETCH. NOP also goes to FETCH with no enables asserted. Everything else goes to EXE.
- EXE:
  - addu: `alu_op`=0, `alu_bsel`=0.
  - subu: `alu_op`=1, `alu_bsel`=0.
  - ori: `eop`=1, `alu_op`=2, `alu_bsel`=1.
  - lui: `eop`=2, `alu_op`=3, `alu_bsel`=1.
  - lw/sw: `eop`=0, `alu_op`=0, `alu_bsel`=1.
  - beq: `alu_op`=1, `alu_bsel`=0, `eop`=3, `npc_sel`=1, `pc_wr`=`zero`.
  - Next state: R-type/ori/lui go to WB; lw/sw go to MEM; beq goes to FETCH.
- MEM: sw asserts `mem_wr`=1 and goes to FETCH. lw asserts no enables and goes to WB.
- WB: `reg_wr`=1. Next state FETCH.
  - R-type: `reg_dst`=1, `wd_sel`=0.
  - ori/lui: `reg_dst`=0, `wd_sel`=0.
  - lw: `reg_dst`=0, `wd_sel`=1.
- Selects not listed for a state are 0. All enables not listed are 0.
- `retire`=1 in the final state of every instruction, including NOPs. `instr_cnt` increments on each edge where `retire`=1 and wraps from 0xFFFFFFFF to 0.

## Timing
- Outputs are combinational from the `state` register and `opcode`/`funct`. The next state registers on the rising edge.
- Cycles per instruction:
  - j/jal/jr/NOP: 2.
  - beq: 3.
  - addu/subu/ori/lui/sw: 4.
  - lw: 5.
- Reset is asynchronous:
  - `state` goes to FETCH and `instr_cnt` to 0 immediately.
  - While `reset`=1, every enable and `retire` is forced to 0; selects and `eop` read 0.
  - The first fetch happens on the first rising edge after deassertion.
- Reset mid-instruction aborts it: no partial write and no retire count.
- `zero` is sampled only in EXE for beq. Its value in any other state is ignored.

## Structure
- Package `mc_pkg`: opcode/funct constants, state encodings, and the `npc_sel`, `eop`, `alu_op`, `reg_dst` and `wd_sel` encodings. The extender uses the same `eop` constants.
- Sub-module `mc_decode`: combinational opcode/funct to one-hot instruction class (rtype_addu, rtype_subu, ori, lui, lw, sw, beq, j, jal, jr, nop).
- `mc_ctrl` holds the state register, the output decode and `instr_cnt`.

## Test plan
- Reset release, then ori (opcode 0x0D) → FETCH, DECODE, EXE (`eop`=1, `alu_bsel`=1), WB (`reg_wr`=1, `reg_dst`=0). `instr_cnt`=1 after 4 cycles.
- beq (0x04) with `zero`=1, then beq with `zero`=0 → EXE shows `eop`=3 and `npc_sel`=1 both times; `pc_wr`=1 then 0; 3 cycles each.
- lw (0x23) then sw (0x2B) → lw takes 5 cycles with WB `wd_sel`=1; sw takes 4 cycles with `mem_wr`=1 only in MEM; `instr_cnt`=2.
- jal (0x03) → DECODE shows `pc_wr`=1, `npc_sel`=2, `reg_wr`=1, `reg_dst`=2, `wd_sel`=2; back in FETCH next cycle. Then opcode 0x3F (NOP) → 2 cycles, no enables, `retire` pulses.
- lui (0x0F) with `reset` asserted during EXE → `state`=FETCH immediately; `reg_wr` never asserted; `instr_cnt`=0.
- `instr_cnt` preloaded/forced to 0xFFFFFFFF, then one retire → `instr_cnt`=0.
